// File: rtl/tmp_pkg.sv
// Shared types and defaults for the temperature-sensor phase interface: receiver FSM states,
// controller phase encoding, default widths and the offset-binary midpoint helper.
package tmp_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int OSR_DEF   = 4;
  localparam int ACC_W_DEF = 10;

  typedef enum logic {ST_SYNC, ST_ACQ} rx_state_e;

  typedef enum logic [1:0] {PH_PRECHARGE, PH_PI1, PH_PI2, PH_OUTPUT} ctrl_phase_e;

  // Midpoint of an acc_w-bit offset-binary code.
  function automatic int unsigned code_offset(input int unsigned acc_w);
    return 32'd1 << (acc_w - 1);
  endfunction

endpackage

// File: rtl/tmp_code_obuf.sv
// One-entry valid/ready output register; a load lands 1 clock later. When the entry is full and
// not being drained, a new load is dropped, the held code stays stable and overrun sets (sticky).
module tmp_code_obuf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         overrun
);

  logic accept;

  assign accept = code_valid & code_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load && (!code_valid || accept)) begin
      code       <= data;
      code_valid <= 1'b1;
    end else if (load) begin
      overrun    <= 1'b1;
    end else if (accept) begin
      code_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tmp_code_rx.sv
// Decodes big-diode charge-balance steps into OSR-frame offset-binary codes; code is valid 1 clock
// after the closing PD rise and is held until accepted (a result arriving while full is dropped).
module tmp_code_rx
  import tmp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OSR   = OSR_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PI2,
  input  logic             snk,
  input  logic             src_n,
  input  logic             PD,
  output logic [ACC_W-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             overrun,
  output logic             step_err
);

  localparam int FRM_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [FRM_W-1:0]        FRM_LAST = FRM_W'(OSR - 1);
  localparam logic [ACC_W-1:0]        OFFSET   = ACC_W'(code_offset(ACC_W));
  localparam logic signed [CNT_W-1:0] STEP_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] STEP_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  rx_state_e               state, state_nxt;
  logic                    pd_q, pd_rise;
  logic signed [CNT_W-1:0] step_cnt, step_upd, step_nxt;
  logic [FRM_W-1:0]        frame_cnt, frame_nxt;
  logic signed [ACC_W-1:0] acc, acc_sum, acc_nxt;
  logic                    err_set, result_load;
  logic [ACC_W-1:0]        result;

  // pd_q resets high so a PD already high during precharge is not taken as a frame edge.
  assign pd_rise = PD & ~pd_q;
  assign result  = acc_sum + OFFSET;

  always_comb begin
    state_nxt   = state;
    step_upd    = step_cnt;
    step_nxt    = step_cnt;
    frame_nxt   = frame_cnt;
    acc_nxt     = acc;
    acc_sum     = acc;
    err_set     = 1'b0;
    result_load = 1'b0;
    if (state == ST_SYNC) begin
      if (pd_rise) begin
        state_nxt = ST_ACQ;
        step_nxt  = '0;
        frame_nxt = '0;
        acc_nxt   = '0;
      end
    end else begin
      if (PI2) begin
        if (snk && !src_n && step_cnt != STEP_MAX) begin
          step_upd = step_cnt + 1'b1;
        end else if (src_n && !snk && step_cnt != STEP_MIN) begin
          step_upd = step_cnt - 1'b1;
        end else if (snk && src_n) begin
          err_set = 1'b1;
        end
      end
      step_nxt = step_upd;
      // A step landing on the closing edge still belongs to the frame it ends.
      acc_sum  = acc + ACC_W'(step_upd);
      if (pd_rise) begin
        step_nxt = '0;
        if (frame_cnt == FRM_LAST) begin
          result_load = 1'b1;
          acc_nxt     = '0;
          frame_nxt   = '0;
        end else begin
          acc_nxt     = acc_sum;
          frame_nxt   = frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SYNC;
      pd_q      <= 1'b1;
      step_cnt  <= '0;
      frame_cnt <= '0;
      acc       <= '0;
      step_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pd_q      <= PD;
      step_cnt  <= step_nxt;
      frame_cnt <= frame_nxt;
      acc       <= acc_nxt;
      step_err  <= step_err | err_set;
    end
  end

  tmp_code_obuf #(
    .W(ACC_W)
  ) u_obuf (
    .clk        (clk),
    .reset      (reset),
    .load       (result_load),
    .data       (result),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_tmp_code_rx.sv
// Directed bench for tmp_code_rx: frame stimulus tasks plus one task per scenario, each with
// hand-computed expected codes for the default CNT_W=8, OSR=4, ACC_W=10 configuration.
module tb_tmp_code_rx;
  import tmp_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PI2 = 1'b0;
  logic       snk = 1'b0;
  logic       src_n = 1'b0;
  logic       PD = 1'b0;
  logic       code_ready = 1'b0;
  logic [9:0] code;
  logic       code_valid;
  logic       overrun;
  logic       step_err;

  int total = 0;
  int bad   = 0;

  tmp_code_rx dut (
    .clk        (clk),
    .reset      (reset),
    .PI2        (PI2),
    .snk        (snk),
    .src_n      (src_n),
    .PD         (PD),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .step_err   (step_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; PI2 = 1'b0; snk = 1'b0; src_n = 1'b0; PD = 1'b0; code_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic sync();
    PD = 1'b0; tick();
    PD = 1'b1; tick();
    PD = 1'b0;
  endtask

  // One idle cycle with PD low, the steps, then PD raised; the edge itself is pd_edge().
  task automatic frame_steps(input int ups, input int downs);
    PD = 1'b0; PI2 = 1'b0; snk = 1'b0; src_n = 1'b0;
    tick();
    PI2 = 1'b1;
    for (int i = 0; i < ups; i++) begin snk = 1'b1; tick(); end
    snk = 1'b0;
    for (int i = 0; i < downs; i++) begin src_n = 1'b1; tick(); end
    src_n = 1'b0; PI2 = 1'b0;
    PD = 1'b1;
  endtask

  task automatic pd_edge();
    tick();
    PD = 1'b0; PI2 = 1'b0; snk = 1'b0; src_n = 1'b0;
  endtask

  task automatic frame(input int ups, input int downs);
    frame_steps(ups, downs);
    pd_edge();
  endtask

  task automatic test_reset();
    reset = 1'b1; PD = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (code !== 10'd0) begin $display("FAIL reset_code got=%0d exp=0", code); bad++; end
    total++; if (code_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", code_valid); bad++; end
    total++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun got=%b exp=0", overrun); bad++; end
    total++; if (step_err !== 1'b0) begin $display("FAIL reset_step_err got=%b exp=0", step_err); bad++; end
  endtask

  // PD held high out of reset must not sync; only the later 0->1 does.
  task automatic test_sync_accumulate();
    for (int i = 0; i < 3; i++) tick();
    total++; if (code_valid !== 1'b0) begin $display("FAIL pd_hold_valid got=%b exp=0", code_valid); bad++; end
    sync();
    for (int i = 0; i < 3; i++) frame(3, 0);
    total++; if (code_valid !== 1'b0) begin $display("FAIL sync_early_code got=%b exp=0", code_valid); bad++; end
    frame(3, 0);
    total++; if (code_valid !== 1'b1) begin $display("FAIL sync_valid got=%b exp=1", code_valid); bad++; end
    total++; if (code !== 10'd524) begin $display("FAIL sync_code got=%0d exp=524", code); bad++; end
    code_ready = 1'b1; tick(); code_ready = 1'b0;
    total++; if (code_valid !== 1'b0) begin $display("FAIL sync_accept got=%b exp=0", code_valid); bad++; end
    total++; if (code !== 10'd524) begin $display("FAIL sync_code_kept got=%0d exp=524", code); bad++; end
  endtask

  task automatic test_latency_updown();
    apply_reset(); sync();
    for (int i = 0; i < 3; i++) frame(5, 7);
    frame_steps(5, 7);
    total++; if (code_valid !== 1'b0) begin $display("FAIL lat_pre_edge got=%b exp=0", code_valid); bad++; end
    pd_edge();
    total++; if (code_valid !== 1'b1) begin $display("FAIL lat_valid got=%b exp=1", code_valid); bad++; end
    total++; if (code !== 10'd504) begin $display("FAIL updown_code got=%0d exp=504", code); bad++; end
  endtask

  task automatic test_saturate();
    apply_reset(); sync();
    frame(200, 0);
    for (int i = 0; i < 3; i++) frame(0, 0);
    total++; if (code_valid !== 1'b1) begin $display("FAIL sat_valid got=%b exp=1", code_valid); bad++; end
    total++; if (code !== 10'd639) begin $display("FAIL sat_code got=%0d exp=639", code); bad++; end
  endtask

  // Up step asserted on the same cycle as the PD rise counts toward the closing frame.
  task automatic test_edge_step();
    apply_reset(); sync();
    for (int i = 0; i < 4; i++) begin
      frame_steps(2, 0);
      PI2 = 1'b1; snk = 1'b1;
      pd_edge();
    end
    total++; if (code !== 10'd524) begin $display("FAIL edge_step_code got=%0d exp=524", code); bad++; end
  endtask

  task automatic test_overrun();
    apply_reset(); sync();
    for (int i = 0; i < 4; i++) frame(1, 0);
    total++; if (code !== 10'd516) begin $display("FAIL ovr_first_code got=%0d exp=516", code); bad++; end
    total++; if (overrun !== 1'b0) begin $display("FAIL ovr_early got=%b exp=0", overrun); bad++; end
    for (int i = 0; i < 4; i++) frame(2, 0);
    total++; if (code !== 10'd516) begin $display("FAIL ovr_code_held got=%0d exp=516", code); bad++; end
    total++; if (code_valid !== 1'b1) begin $display("FAIL ovr_valid_held got=%b exp=1", code_valid); bad++; end
    total++; if (overrun !== 1'b1) begin $display("FAIL ovr_flag got=%b exp=1", overrun); bad++; end
    code_ready = 1'b1; tick(); code_ready = 1'b0;
    total++; if (code_valid !== 1'b0) begin $display("FAIL ovr_drain got=%b exp=0", code_valid); bad++; end
    total++; if (code !== 10'd516) begin $display("FAIL ovr_code_after got=%0d exp=516", code); bad++; end
    total++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got=%b exp=1", overrun); bad++; end
  endtask

  task automatic test_back_to_back();
    apply_reset(); sync();
    for (int i = 0; i < 4; i++) frame(1, 0);
    for (int i = 0; i < 3; i++) frame(3, 0);
    frame_steps(3, 0);
    code_ready = 1'b1;
    pd_edge();
    code_ready = 1'b0;
    total++; if (code !== 10'd524) begin $display("FAIL b2b_code got=%0d exp=524", code); bad++; end
    total++; if (code_valid !== 1'b1) begin $display("FAIL b2b_valid got=%b exp=1", code_valid); bad++; end
    total++; if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got=%b exp=0", overrun); bad++; end
  endtask

  task automatic test_step_err();
    apply_reset(); sync();
    total++; if (step_err !== 1'b0) begin $display("FAIL err_clear got=%b exp=0", step_err); bad++; end
    PI2 = 1'b1; snk = 1'b1; src_n = 1'b1; tick();
    total++; if (step_err !== 1'b1) begin $display("FAIL err_set got=%b exp=1", step_err); bad++; end
    PI2 = 1'b0; src_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    snk = 1'b0; src_n = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    src_n = 1'b0; PI2 = 1'b1; snk = 1'b1; tick();
    PI2 = 1'b0; snk = 1'b0; PD = 1'b1;
    pd_edge();
    for (int i = 0; i < 3; i++) frame(0, 0);
    total++; if (code !== 10'd513) begin $display("FAIL err_code got=%0d exp=513", code); bad++; end
  endtask

  task automatic test_reset_mid();
    apply_reset(); sync();
    for (int i = 0; i < 4; i++) frame(1, 0);
    PI2 = 1'b1; snk = 1'b1; src_n = 1'b1; tick();
    src_n = 1'b0; tick();
    total++; if (step_err !== 1'b1 || code_valid !== 1'b1) begin
      $display("FAIL mid_pre got=%b%b exp=11", step_err, code_valid); bad++; end
    reset = 1'b1; PI2 = 1'b0; snk = 1'b0; tick(); reset = 1'b0;
    total++; if (code !== 10'd0) begin $display("FAIL mid_code got=%0d exp=0", code); bad++; end
    total++; if (code_valid !== 1'b0) begin $display("FAIL mid_valid got=%b exp=0", code_valid); bad++; end
    total++; if (step_err !== 1'b0) begin $display("FAIL mid_step_err got=%b exp=0", step_err); bad++; end
    total++; if (overrun !== 1'b0) begin $display("FAIL mid_overrun got=%b exp=0", overrun); bad++; end
    for (int i = 0; i < 4; i++) frame(2, 0);
    total++; if (code_valid !== 1'b0) begin $display("FAIL mid_resync_early got=%b exp=0", code_valid); bad++; end
    frame(2, 0);
    total++; if (code_valid !== 1'b1) begin $display("FAIL mid_resync_valid got=%b exp=1", code_valid); bad++; end
    total++; if (code !== 10'd520) begin $display("FAIL mid_resync_code got=%0d exp=520", code); bad++; end
  endtask

  initial begin
    test_reset();
    test_sync_accumulate();
    test_latency_updown();
    test_saturate();
    test_edge_step();
    test_overrun();
    test_back_to_back();
    test_step_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
